// File: rtl/pipe_adder_pkg.sv
// ----------------------------------------------------------------------------
// pipe_adder_pkg
//   Shared constants and types for the pipelined adder/subtractor.
//   DEF_WIDTH  : default operand/sum width in bits
//   DEF_STAGES : default number of register slices
//   mode_e     : operation select carried on the 'sub' port (ADD=0, SUB=1)
// ----------------------------------------------------------------------------
package pipe_adder_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_STAGES = 2;

   typedef enum logic {
      ADD = 1'b0,
      SUB = 1'b1
   } mode_e;

endpackage : pipe_adder_pkg

// File: rtl/add_slice.sv
// ----------------------------------------------------------------------------
// add_slice
//   W-bit combinational ripple adder used once per pipeline stage.
//   a, b : slice operands
//   ci   : carry into the slice LSB
//   s    : slice sum
//   co   : carry out of the slice MSB
// ----------------------------------------------------------------------------
module add_slice
   import pipe_adder_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   // One extra bit on each operand so the MSB carry lands in 'co'.
   assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule : add_slice

// File: rtl/pipe_adder.sv
// ----------------------------------------------------------------------------
// pipe_adder
//   Pipelined add/subtract unit with valid/ready handshakes on both sides.
//   The operands are split into STAGES slices of WIDTH/STAGES bits; stage k
//   adds slice k using the carry registered by stage k-1, while the operand
//   slices still to be added and the sum slices already produced travel
//   forward in the stage registers. Latency is STAGES cycles.
//
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin, sub)
//   sub                 : 0 = a + b + cin, 1 = a + ~b + ~cin (a - b - cin)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   cout                : carry out of the MSB (in subtract mode 1 = no borrow)
//   ovf                 : two's-complement signed overflow
// ----------------------------------------------------------------------------
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int W    = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   // Subtraction is addition of the inverted operand with inverted carry-in.
   mode_e            mode;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   assign mode    = mode_e'(sub);
   assign b_eff   = (mode == SUB) ? ~b : b;
   assign cin_eff = cin ^ (mode == SUB);

   // Stage registers: ar_q/br_q hold the operand slices not yet added,
   // shifted down so the next slice to add always sits in bits [W-1:0].
   logic             vld_q [STAGES];
   logic             c_q   [STAGES];
   logic [WIDTH-1:0] ar_q  [STAGES];
   logic [WIDTH-1:0] br_q  [STAGES];
   logic [WIDTH-1:0] sum_q [STAGES];
   logic             ovf_q;

   // Per-stage combinational inputs and slice adder results.
   logic             vld_in   [STAGES];
   logic             c_in     [STAGES];
   logic [WIDTH-1:0] ar_in    [STAGES];
   logic [WIDTH-1:0] br_in    [STAGES];
   logic [WIDTH-1:0] sum_in   [STAGES];
   logic [W-1:0]     s_slice  [STAGES];
   logic             co_slice [STAGES];
   logic             ovf_nxt;
   logic             adv;

   // Global stall: every stage moves together unless a finished result is
   // being held back. An empty output stage always lets bubbles advance.
   assign adv      = !vld_q[LAST] || out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign vld_in[k] = in_valid;
         assign c_in[k]   = cin_eff;
         assign ar_in[k]  = a;
         assign br_in[k]  = b_eff;
         assign sum_in[k] = '0;
      end else begin : g_body
         assign vld_in[k] = vld_q[k-1];
         assign c_in[k]   = c_q[k-1];
         assign ar_in[k]  = ar_q[k-1];
         assign br_in[k]  = br_q[k-1];
         assign sum_in[k] = sum_q[k-1];
      end

      add_slice #(.W(W)) u_slice (
         .a  (ar_in[k][W-1:0]),
         .b  (br_in[k][W-1:0]),
         .ci (c_in[k]),
         .s  (s_slice[k]),
         .co (co_slice[k])
      );

      // NOTE: state registers use non-blocking assignments so every stage
      // samples the values its neighbour held before this edge.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            // NOTE: data registers are cleared along with the valid bits so
            // the outputs read as zero after reset rather than as X.
            vld_q[k] <= 1'b0;
            c_q[k]   <= 1'b0;
            ar_q[k]  <= '0;
            br_q[k]  <= '0;
            sum_q[k] <= '0;
         end else if (adv) begin
            vld_q[k] <= vld_in[k];
            c_q[k]   <= co_slice[k];
            ar_q[k]  <= ar_in[k] >> W;
            br_q[k]  <= br_in[k] >> W;
            sum_q[k] <= sum_in[k] | (WIDTH'(s_slice[k]) << (k * W));
         end
      end
   end

   // The last stage adds the top slice, so its MSBs are the operand and sum
   // sign bits needed for signed overflow.
   assign ovf_nxt = (ar_in[LAST][W-1] == br_in[LAST][W-1]) &&
                    (s_slice[LAST][W-1] != ar_in[LAST][W-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (adv) begin
         ovf_q <= ovf_nxt;
      end
   end

   assign out_valid = vld_q[LAST];
   assign sum       = sum_q[LAST];
   assign cout      = c_q[LAST];
   assign ovf       = ovf_q;

endmodule : pipe_adder

// File: tb/tb_pipe_adder.sv
// ----------------------------------------------------------------------------
// tb_pipe_adder
//   Directed bench for pipe_adder at WIDTH=8 with STAGES=2, 1 and 8 side by
//   side (index 0, 1, 2). Expected results are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_pipe_adder;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [2:0]      in_valid, in_ready, cin, sub;
   logic [2:0]      out_valid, out_ready, cout, ovf;
   logic [2:0][7:0] a, b, sum;

   int tests = 0;
   int fails = 0;
   int lat [3] = '{2, 1, 8};

   always #5 clk = ~clk;

   pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut_s2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a[0]), .b(b[0]), .cin(cin[0]), .sub(sub[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0]));

   pipe_adder #(.WIDTH(8), .STAGES(1)) u_dut_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a[1]), .b(b[1]), .cin(cin[1]), .sub(sub[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1]));

   pipe_adder #(.WIDTH(8), .STAGES(8)) u_dut_s8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a(a[2]), .b(b[2]), .cin(cin[2]), .sub(sub[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .sum(sum[2]), .cout(cout[2]), .ovf(ovf[2]));

   // Stream vectors: a, b, cin, sub and expected {sum, cout, ovf}.
   logic [7:0] sa_t  [10] = '{8'h12, 8'hF0, 8'h40, 8'h80, 8'h10, 8'h00, 8'h55, 8'h20, 8'h7F, 8'hFF};
   logic [7:0] sb_t  [10] = '{8'h34, 8'h20, 8'h40, 8'h80, 8'h10, 8'h01, 8'h0A, 8'h05, 8'hFF, 8'hFF};
   logic       sc_t  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic       ss_t  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [9:0] exp_t [10] = '{
      {8'h46, 1'b0, 1'b0}, {8'h10, 1'b1, 1'b0}, {8'h80, 1'b0, 1'b1}, {8'h00, 1'b1, 1'b1},
      {8'h00, 1'b1, 1'b0}, {8'hFF, 1'b0, 1'b0}, {8'h60, 1'b0, 1'b0}, {8'h1A, 1'b1, 1'b0},
      {8'h80, 1'b0, 1'b1}, {8'hFF, 1'b1, 1'b0}};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = '0;
      out_ready = '1;
      a = '0; b = '0; cin = '0; sub = '0;
      repeat (2) tick();
      for (int d = 0; d < 3; d++) begin
         tests++;
         if ({out_valid[d], sum[d], cout[d], ovf[d]} !== 11'h000) begin
            fails++;
            $display("FAIL reset_outputs dut%0d got=%h exp=000", d,
                     {out_valid[d], sum[d], cout[d], ovf[d]});
         end
      end
      #3 rst_n = 1'b1;
      tick();
      for (int d = 0; d < 3; d++) begin
         tests++;
         if (in_ready[d] !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready dut%0d got=%b exp=1", d, in_ready[d]);
         end
      end
   endtask

   // One operand set with out_ready held high: out_valid must stay low for
   // lat-1 edges and show the result right after edge lat.
   task automatic test_vector(input int d, input string name,
                              input logic [7:0] va, input logic [7:0] vb,
                              input logic vcin, input logic vsub,
                              input logic [7:0] es, input logic ec, input logic eo);
      tick();
      a[d] = va; b[d] = vb; cin[d] = vcin; sub[d] = vsub;
      in_valid[d]  = 1'b1;
      out_ready[d] = 1'b1;
      #1;
      tests++;
      if (in_ready[d] !== 1'b1) begin
         fails++;
         $display("FAIL %s_ready dut%0d got=%b exp=1", name, d, in_ready[d]);
      end
      for (int c = 1; c <= lat[d]; c++) begin
         tick();
         if (c == 1) in_valid[d] = 1'b0;
         tests++;
         if (c < lat[d]) begin
            if (out_valid[d] !== 1'b0) begin
               fails++;
               $display("FAIL %s_early dut%0d cycle=%0d got=%b exp=0", name, d, c, out_valid[d]);
            end
         end else if ({out_valid[d], sum[d], cout[d], ovf[d]} !== {1'b1, es, ec, eo}) begin
            fails++;
            $display("FAIL %s dut%0d got v=%b sum=%h cout=%b ovf=%b exp v=1 sum=%h cout=%b ovf=%b",
                     name, d, out_valid[d], sum[d], cout[d], ovf[d], es, ec, eo);
         end
      end
   endtask

   task automatic test_arith(input int d);
      test_vector(d, "add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
      test_vector(d, "add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      test_vector(d, "wrap_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      test_vector(d, "sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
      test_vector(d, "sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
   endtask

   // Ten sets streamed with out_ready toggled randomly: results in order,
   // held stable while stalled, in_ready = !out_valid || out_ready.
   task automatic test_back_to_back(input int d);
      int         wr = 0;
      int         rd = 0;
      int         cyc = 0;
      logic       stalled = 1'b0;
      logic       acc;
      logic [9:0] held = '0;
      tick();
      while ((rd < 10) && (cyc < 300)) begin
         out_ready[d] = ($urandom_range(0, 1) != 0);
         if (wr < 10) begin
            in_valid[d] = 1'b1;
            a[d] = sa_t[wr]; b[d] = sb_t[wr]; cin[d] = sc_t[wr]; sub[d] = ss_t[wr];
         end else begin
            in_valid[d] = 1'b0;
         end
         #1;
         tests++;
         if (in_ready[d] !== (!out_valid[d] || out_ready[d])) begin
            fails++;
            $display("FAIL b2b_in_ready dut%0d cycle=%0d got=%b exp=%b", d, cyc,
                     in_ready[d], !out_valid[d] || out_ready[d]);
         end
         if (stalled) begin
            tests++;
            if ({out_valid[d], sum[d], cout[d], ovf[d]} !== {1'b1, held}) begin
               fails++;
               $display("FAIL b2b_stall_hold dut%0d cycle=%0d got=%h exp=%h", d, cyc,
                        {out_valid[d], sum[d], cout[d], ovf[d]}, {1'b1, held});
            end
         end
         if (out_valid[d] && out_ready[d]) begin
            tests++;
            if ({sum[d], cout[d], ovf[d]} !== exp_t[rd]) begin
               fails++;
               $display("FAIL b2b_result dut%0d item=%0d got=%h exp=%h", d, rd,
                        {sum[d], cout[d], ovf[d]}, exp_t[rd]);
            end
            rd++;
         end
         stalled = out_valid[d] && !out_ready[d];
         held    = {sum[d], cout[d], ovf[d]};
         acc     = in_valid[d] && in_ready[d];
         @(posedge clk);
         #1;
         if (acc) wr++;
         cyc++;
      end
      tests++;
      if (rd != 10) begin
         fails++;
         $display("FAIL b2b_timeout dut%0d got=%0d results exp=10", d, rd);
      end
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      for (int c = 0; c < lat[d] + 2; c++) begin
         tick();
         tests++;
         if (out_valid[d] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_extra_result dut%0d cycle=%0d got=%b exp=0", d, c, out_valid[d]);
         end
      end
   endtask

   // Two results in flight on the STAGES=2 unit, then reset pulsed.
   task automatic test_reset_flight();
      tick();
      out_ready[0] = 1'b1;
      in_valid[0]  = 1'b1;
      a[0] = 8'h11; b[0] = 8'h22; cin[0] = 1'b0; sub[0] = 1'b0;
      tick();
      a[0] = 8'h33; b[0] = 8'h44;
      tick();
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b0;
      #1;
      tests++;
      if (out_valid[0] !== 1'b1) begin
         fails++;
         $display("FAIL flight_loaded dut0 got=%b exp=1", out_valid[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         tests++;
         if ({out_valid[d], sum[d], cout[d], ovf[d]} !== 11'h000) begin
            fails++;
            $display("FAIL flight_reset dut%0d got=%h exp=000", d,
                     {out_valid[d], sum[d], cout[d], ovf[d]});
         end
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      out_ready[0] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         tests++;
         if (out_valid[0] !== 1'b0) begin
            fails++;
            $display("FAIL flight_stale dut0 cycle=%0d got=%b exp=0", c, out_valid[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      for (int d = 0; d < 3; d++) test_arith(d);
      for (int d = 0; d < 3; d++) test_back_to_back(d);
      test_reset_flight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_pipe_adder
